// File: rtl/scalar_loop_sequencer.sv
// scalar_loop_sequencer: multi-cycle micro-sequencer for one PE_scalar lane.
// Fetches from a small program memory, drives the PE from a scalar register
// file, writes PE results back and branches on the PE's flag_neq.
// Each instruction costs a FETCH and an EXEC cycle; halt adds a DONE cycle and
// the done pulse is registered, so start -> done is 2*N+2 cycles.
// Optional feature: define SCALAR_SEQ_WATCHDOG_EN to abort a program that has
// not halted after WDOG_MAX EXEC cycles (err=1, done pulses).
module scalar_loop_sequencer #(
  parameter int DWIDTH   = 32,
  parameter int RF_AW    = 4,
  parameter int IMMW     = 12,
  parameter int PC_AW    = 5,
  parameter int IW       = 3 + 3*RF_AW + IMMW,
  parameter int WDOG_MAX = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              prog_we_i,
  input  logic [PC_AW-1:0]  prog_addr_i,
  input  logic [IW-1:0]     prog_data_i,
  input  logic [RF_AW-1:0]  rf_raddr_i,
  output logic [DWIDTH-1:0] rf_rdata_o,
  output logic [2:0]        pe_op_o,
  output logic [DWIDTH-1:0] pe_inp1_o,
  output logic [DWIDTH-1:0] pe_inp2_o,
  output logic [DWIDTH-1:0] pe_imm_o,
  input  logic [DWIDTH-1:0] pe_out1_i,
  input  logic              pe_flag_neq_i,
  output logic              err_o
);

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b100;
  localparam logic [2:0] PE_IDLE = 3'b111;  // PE answers 0 / flag 0 for this op

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PC_AW-1:0]   pc_q, pc_d;
  logic               done_q, done_d;
  logic [IW-1:0]      instr_q;
  logic [IW-1:0]      prog_mem [2**PC_AW];
  logic [DWIDTH-1:0]  rf_q [2**RF_AW];
  logic               rf_we;
  logic [DWIDTH-1:0]  rf_wdata;
  logic               prog_wr;

  // Instruction field decode of the registered instruction.
  logic [2:0]         op;
  logic [RF_AW-1:0]   rd, rs1, rs2;
  logic [IMMW-1:0]    imm;
  logic [DWIDTH-1:0]  imm_sext;

  assign op       = instr_q[2:0];
  assign rd       = instr_q[3 +: RF_AW];
  assign rs1      = instr_q[3+RF_AW +: RF_AW];
  assign rs2      = instr_q[3+2*RF_AW +: RF_AW];
  assign imm      = instr_q[IW-1 -: IMMW];
  assign imm_sext = {{(DWIDTH-IMMW){imm[IMMW-1]}}, imm};

  // RF[0] is never written and resets to 0, so it always reads as 0.
  assign rf_rdata_o = rf_q[rf_raddr_i];
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

`ifdef SCALAR_SEQ_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_MAX + 1);
  logic [WCW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  assign err_o = err_q;

  // Watchdog: EXEC-cycle counter and sticky abort flag, both cleared on start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
`else
  assign err_o = 1'b0;
`endif

  // Next-state, PE drive and RF write-back control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    done_d    = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    prog_wr   = 1'b0;
    pe_op_o   = PE_IDLE;
    pe_inp1_o = '0;
    pe_inp2_o = '0;
    pe_imm_o  = '0;
`ifdef SCALAR_SEQ_WATCHDOG_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
`ifdef SCALAR_SEQ_WATCHDOG_EN
          wdog_d  = '0;
          err_d   = 1'b0;
`endif
        end else begin
          // A write coinciding with start is dropped.
          prog_wr = prog_we_i;
        end
      end
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        pe_op_o   = op;
        pe_inp1_o = rf_q[rs1];
        pe_inp2_o = rf_q[rs2];
        pe_imm_o  = imm_sext;
        state_d   = S_FETCH;
        pc_d      = pc_q + PC_AW'(1);
        case (op)
          OP_LUI: begin
            rf_we    = 1'b1;
            rf_wdata = imm_sext;
          end
          OP_ADDI, OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = pe_out1_i;
          end
          OP_BNE: begin
            // Branch target wraps modulo the program depth.
            if (pe_flag_neq_i) pc_d = pc_q + imm_sext[PC_AW-1:0];
          end
          OP_HALT: begin
            state_d = S_DONE;
            pc_d    = pc_q;
          end
          default: ;
        endcase
`ifdef SCALAR_SEQ_WATCHDOG_EN
        wdog_d = wdog_q + WCW'(1);
        if (op != OP_HALT && wdog_d == WCW'(WDOG_MAX)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, program counter and registered done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // Register file: cleared on reset, writes to rd=0 discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**RF_AW; i++) rf_q[i] <= '0;
    end else if (rf_we && rd != '0) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  // Program memory (not reset): write port in IDLE, registered fetch read.
  always_ff @(posedge clk_i) begin
    if (prog_wr) prog_mem[prog_addr_i] <= prog_data_i;
    if (state_q == S_FETCH) instr_q <= prog_mem[pc_q];
  end

endmodule

// File: tb/tb_scalar_loop_sequencer.sv
// Bench for scalar_loop_sequencer: directed programs plus random counted
// loops, compared against an instruction-level interpreter of the program.
module tb_scalar_loop_sequencer;

  localparam int IW = 27;
`ifdef SCALAR_SEQ_WATCHDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [26:0] prog_data = '0;
  logic [3:0]  rf_raddr = '0;
  logic        busy, done, err, pe_flag_neq;
  logic [31:0] rf_rdata, pe_inp1, pe_inp2, pe_imm, pe_out1;
  logic [2:0]  pe_op;

  scalar_loop_sequencer #(.WDOG_MAX((WDOG == 0) ? 1024 : WDOG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .rf_raddr_i(rf_raddr), .rf_rdata_o(rf_rdata), .pe_op_o(pe_op),
    .pe_inp1_o(pe_inp1), .pe_inp2_o(pe_inp2), .pe_imm_o(pe_imm),
    .pe_out1_i(pe_out1), .pe_flag_neq_i(pe_flag_neq), .err_o(err)
  );

  always #5 clk = ~clk;

  // Minimal PE_scalar: addi, add, bne comparison; everything else answers 0.
  always_comb begin
    pe_out1     = '0;
    pe_flag_neq = 1'b0;
    case (pe_op)
      3'b001:  pe_out1 = pe_inp1 + pe_imm;
      3'b011:  pe_out1 = pe_inp1 + pe_inp2;
      3'b010:  pe_flag_neq = (pe_inp1 != pe_inp2);
      default: ;
    endcase
  end

  // Count taken branches mid-cycle, away from the active edge.
  int taken_cnt = 0;
  always @(negedge clk) if (pe_op == 3'b010 && pe_flag_neq) taken_cnt++;

  logic [31:0] rf_m [16];
  logic [26:0] mem_m [32];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [11:0] i12;
    i12 = imm[11:0];
    return {i12, rs2[3:0], rs1[3:0], rd[3:0], op[2:0]};
  endfunction

  function automatic logic [26:0] rand_insn();
    int k   = $urandom_range(0, 3);
    int rd  = $urandom_range(0, 13);
    int rs1 = $urandom_range(0, 15);
    int rs2 = $urandom_range(0, 15);
    int imm = $urandom_range(0, 4095);
    case (k)
      0:       return enc(0, rd, rs1, rs2, imm);
      1:       return enc(1, rd, rs1, rs2, imm);
      2:       return enc(3, rd, rs1, rs2, imm);
      default: return enc($urandom_range(5, 7), rd, rs1, rs2, imm);
    endcase
  endfunction

  // Interpret the program in mem_m from pc 0, updating rf_m.
  task automatic model_run(output int n, output int tk, output bit e);
    int pc, pc_nx, rd, rs1, rs2;
    logic [26:0] ins;
    logic [2:0]  op;
    logic [31:0] imm;
    pc = 0; n = 0; tk = 0; e = 1'b0;
    while (n < 10000) begin
      ins = mem_m[pc];
      op  = ins[2:0];
      rd  = int'(ins[6:3]);
      rs1 = int'(ins[10:7]);
      rs2 = int'(ins[14:11]);
      imm = {{20{ins[26]}}, ins[26:15]};
      n++;
      if (op == 3'd4) break;
      pc_nx = (pc + 1) & 31;
      case (op)
        3'd0: if (rd != 0) rf_m[rd] = imm;
        3'd1: if (rd != 0) rf_m[rd] = rf_m[rs1] + imm;
        3'd3: if (rd != 0) rf_m[rd] = rf_m[rs1] + rf_m[rs2];
        3'd2: if (rf_m[rs1] != rf_m[rs2]) begin
          pc_nx = (pc + $signed(imm)) & 31;
          tk++;
        end
        default: ;
      endcase
      pc = pc_nx;
      if (WDOG != 0 && n == WDOG) begin
        e = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_prog(input logic [26:0] p[$]);
    logic [26:0] d;
    for (int a = 0; a < 32; a++) begin
      d = (a < p.size()) ? p[a] : enc(4, 0, 0, 0, 0);
      prog_we = 1'b1; prog_addr = 5'(a); prog_data = d;
      mem_m[a] = d;
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic check_rf_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      rf_raddr = 4'(i);
      #1;
      check_eq($sformatf("%s r%0d", tag, i), rf_rdata, rf_m[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    rf_raddr = 4'(idx);
    #1;
    check_eq(tag, rf_rdata, exp);
    @(posedge clk); #1;
  endtask

  // Run the loaded program; optional stray writes/starts must have no effect.
  task automatic run_and_check(input string tag, input bit wr_busy, input bit wr_start,
                               input bit start_busy, input logic [4:0] waddr,
                               output int cyc, output int taken);
    int n_exp, tk_exp, cyc_exp, tk0;
    bit err_exp, seen_done, busy_bad;
    logic [26:0] junk;
    model_run(n_exp, tk_exp, err_exp);
    cyc_exp = 2 * n_exp + 2;
    junk = enc(0, 7, 0, 0, 'h55);
    tk0 = taken_cnt;
    start = 1'b1;
    if (wr_start) begin prog_we = 1'b1; prog_addr = waddr; prog_data = junk; end
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0; cyc = 1;
    check_eq({tag, " busy"}, busy, 1);
    seen_done = 0; busy_bad = 0;
    while (cyc < cyc_exp + 20) begin
      if (done) begin seen_done = 1; break; end
      if (!busy) busy_bad = 1;
      if (wr_busy) begin prog_we = 1'b1; prog_addr = waddr; prog_data = junk; end
      start = (start_busy && cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    prog_we = 1'b0; start = 1'b0;
    taken = taken_cnt - tk0;
    check_eq({tag, " cycles"}, seen_done ? cyc : -1, cyc_exp);
    check_eq({tag, " busy held"}, busy_bad, 0);
    check_eq({tag, " busy at done"}, busy, 0);
    check_eq({tag, " err"}, err, err_exp);
    check_eq({tag, " taken"}, taken, tk_exp);
    @(posedge clk); #1;
    check_eq({tag, " done 1 cycle"}, done, 0);
    $display("run %s: instr=%0d cycles=%0d taken=%0d err=%0d", tag, n_exp, cyc, taken, err);
    check_rf_all(tag);
  endtask

  initial begin
    logic [26:0] p[$];
    int cyc, tk;
    bit done_seen;
    for (int i = 0; i < 16; i++) rf_m[i] = '0;

    // Reset state.
    repeat (2) @(posedge clk); #1;
    check_eq("rst busy", busy, 0);
    check_eq("rst pe_op", pe_op, 3'b111);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle busy", busy, 0);
    check_eq("idle done", done, 0);
    check_eq("idle err", err, 0);
    check_eq("idle pe_op", pe_op, 3'b111);
    check_eq("idle pe_inp1", pe_inp1, 0);
    check_rf_all("reset");

    // Straight-line arithmetic.
    p = {enc(0, 1, 0, 0, 5), enc(1, 2, 1, 0, -3), enc(3, 3, 1, 2, 0), enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("progA", 0, 0, 0, 5'd0, cyc, tk);
    check_eq("progA latency", cyc, 10);
    check_reg("progA r1", 1, 32'd5);
    check_reg("progA r2", 2, 32'd2);
    check_reg("progA r3", 3, 32'd7);

    // Counted loop.
    p = {enc(0, 1, 0, 0, 0), enc(0, 2, 0, 0, 4), enc(1, 1, 1, 0, 1), enc(2, 0, 1, 2, -1),
         enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("loop", 0, 0, 1, 5'd0, cyc, tk);
    check_eq("loop latency", cyc, 24);
    check_eq("loop taken", tk, 3);
    check_reg("loop r1", 1, 32'd4);

    // Branch at pc 0 wrapping to pc 31 (halt).
    p = {enc(2, 0, 1, 0, -1), enc(0, 6, 0, 0, 'h123)};
    load_prog(p);
    run_and_check("wrap", 0, 0, 0, 5'd0, cyc, tk);
    check_eq("wrap latency", cyc, 6);
    check_reg("wrap r6", 6, 32'd0);

    // Writes to r0 are discarded.
    p = {enc(1, 0, 0, 0, 9), enc(3, 5, 0, 0, 0), enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("r0", 0, 0, 0, 5'd0, cyc, tk);
    check_reg("r0 r0", 0, 32'd0);
    check_reg("r0 r5", 5, 32'd0);

    // Not-taken bne.
    p = {enc(0, 1, 0, 0, 0), enc(2, 0, 0, 1, 0), enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("ntaken", 0, 0, 0, 5'd0, cyc, tk);
    check_eq("ntaken taken", tk, 0);

    // Program writes while busy or together with start are dropped.
    p = {enc(0, 7, 0, 0, 1), enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("we_busy", 1, 0, 0, 5'd1, cyc, tk);
    run_and_check("we_start", 0, 1, 0, 5'd0, cyc, tk);
    run_and_check("we_after", 0, 0, 0, 5'd0, cyc, tk);
    check_reg("we r7", 7, 32'd1);

    // Reset mid-run: busy drops at once, no done pulse, RF cleared.
    p = {enc(0, 1, 0, 0, 1), enc(2, 0, 0, 1, 0)};
    load_prog(p);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) done_seen = 1;
      @(posedge clk); #1;
    end
    check_eq("midrst busy before", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst busy async", busy, 0);
    check_eq("midrst pe_op", pe_op, 3'b111);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check_eq("midrst no done", done_seen, 0);
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    check_rf_all("midrst");

`ifdef SCALAR_SEQ_WATCHDOG_EN
    // Runaway loop trips the watchdog; err clears on the next start.
    run_and_check("wdog", 0, 0, 0, 5'd0, cyc, tk);
    check_eq("wdog latency", cyc, 2 * WDOG + 2);
    check_eq("wdog err", err, 1);
    p = {enc(0, 1, 0, 0, 5), enc(4, 0, 0, 0, 0)};
    load_prog(p);
    run_and_check("wdog_clear", 0, 0, 0, 5'd0, cyc, tk);
    check_eq("wdog err cleared", err, 0);
`endif

    // Random programs: prefix, counted loop with random body, halt.
    for (int t = 0; t < 30; t++) begin
      int np, nb, k;
      p = {};
      np = $urandom_range(0, 5);
      for (int i = 0; i < np; i++) p.push_back(rand_insn());
      k = $urandom_range(1, 5);
      p.push_back(enc(0, 14, 0, 0, 0));
      p.push_back(enc(0, 15, 0, 0, k));
      nb = $urandom_range(0, 5);
      for (int i = 0; i < nb; i++) p.push_back(rand_insn());
      p.push_back(enc(1, 14, 14, 0, 1));
      p.push_back(enc(2, 0, 14, 15, -(nb + 1)));
      p.push_back(enc(4, 0, 0, 0, 0));
      load_prog(p);
      run_and_check($sformatf("rand%0d", t), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, 5'd31, cyc, tk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scalar_loop_sequencer.md
Name: scalar_loop_sequencer

Overview:
- Multi-cycle micro-sequencer for one PE_scalar lane.
- Holds a small program memory and scalar register file (RF), fetches and decodes each instruction, and drives op_scalar/inp1/inp2/R_immediate into the PE.
- Writes the PE result back to the RF and takes branches on flag_neq.
- Provides the CGRA loop-control path: counter setup (lui/addi), address arithmetic (add) and loop-back (bne).

Parameters:
- DWIDTH, 32, scalar datapath width (matches dwidth_int).
- RF_AW, 4, RF address width; RF has 2**RF_AW entries.
- IMMW, 12, immediate field width, sign-extended to DWIDTH.
- PC_AW, 5, program address width; program depth is 2**PC_AW.
- IW, 3+3*RF_AW+IMMW (27), instruction width.
- WDOG_MAX, 1024, watchdog instruction limit (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins execution at pc=0 when idle
- busy  out  1  high from the cycle after start until the cycle done pulses
- done  out  1  one-cycle pulse on halt
- prog_we  in  1  program write strobe
- prog_addr  in  PC_AW  program write address
- prog_data  in  IW  instruction word
- rf_raddr  in  RF_AW  debug RF read address
- rf_rdata  out  DWIDTH  debug RF read data, combinational
- pe_op  out  3  to PE op_scalar
- pe_inp1  out  DWIDTH  to PE inp1 (RF[rs1])
- pe_inp2  out  DWIDTH  to PE inp2 (RF[rs2])
- pe_imm  out  DWIDTH  to PE R_immediate (sign-extended imm)
- pe_out1  in  DWIDTH  from PE out1
- pe_flag_neq  in  1  from PE flag_neq
- err  out  1  watchdog abort, sticky until next start (constant 0 without the macro)

Behaviour:
- Instruction fields: op[2:0], rd[3+RF_AW-1:3], rs1 next RF_AW bits, rs2 next RF_AW bits, imm top IMMW bits.
- Opcodes: 000 lui, 001 addi, 010 bne, 011 add, 100 halt; 101-111 are nop.
- Reset (rst=0, async):
  - State IDLE; pc=0; RF cleared to 0; busy=0, done=0, err=0.
  - pe_op=3'b111, so the PE outputs 0 and flag_neq=0.
  - Program memory is not reset.
- States:
  - IDLE: start=1 -> pc=0, go to FETCH.
  - FETCH: register instr=prog[pc], go to EXEC.
  - EXEC: drive PE from the registered instruction. End of cycle:
    - add/addi: RF[rd] <= pe_out1.
    - lui: RF[rd] <= sext(imm); the PE is bypassed.
    - bne: pe_flag_neq=1 -> pc <= pc + sext(imm); else pc <= pc+1.
    - Non-branch: pc <= pc+1.
    - Next state FETCH; halt -> DONE with no RF write.
  - DONE: done=1 for one cycle -> IDLE.
- Cost: 2 cycles per instruction, 1 extra cycle for halt. start -> done latency = 2*N + 2 cycles for N instructions including halt.
- pe_* outputs are valid only in EXEC. Outside EXEC, pe_op=3'b111 and data outputs are 0.
- RF[0] is hardwired to 0; writes to rd=0 are discarded.
- pc arithmetic is modulo 2**PC_AW; branch targets wrap.
- prog_we is honoured only in IDLE and ignored otherwise. In the same cycle, start takes precedence and the write is dropped.
- start while busy is ignored.
- Reset mid-run aborts immediately to IDLE; no done pulse.
- Debug read of RF[x] returns the pre-write value during the write cycle; there is no bypass.

Optional Feature:
- SCALAR_SEQ_WATCHDOG_EN defined:
  - An instruction counter counts EXEC cycles.
  - The counter clears on start.
  - When the count reaches WDOG_MAX without halt: err=1, go to DONE, done pulses.
- Macro absent: no counter is present, err is tied to 0, and a non-halting program runs until reset.

Test Plan:
- Reset then debug-read all RF entries -> all 0; busy=0, done=0, pe_op=3'b111.
- Program {lui r1,5; addi r2,r1,-3; add r3,r1,r2; halt}, then start -> done on cycle 10 after start; r1=5, r2=2, r3=7.
- Loop {lui r1,0; lui r2,4; addi r1,r1,1; bne r1,r2,-1; halt} -> r1=4; bne taken 3 times; done after 2*(2+4*2+1)+2=24 cycles.
- Write to r0 (addi r0,r0,9) and wrap-around branch (bne at pc=0 with imm=-1, target 31 holding halt) -> r0 reads 0; halt executes from pc 31.
- prog_we asserted while busy, and asserted together with start -> program memory unchanged in both cases; assert rst low mid-loop -> busy drops asynchronously, no done.
- Macro on, WDOG_MAX=16, program {bne r0,r1,0} with r1=0 via lui -> not-taken path; use infinite loop {lui r1,1; bne r0,r1,0} -> err=1 and done after 16 EXEC cycles; err clears on the next start.
